// File: rtl/gc_updt_wr_pkg.sv
// Shared TLP codes and FSM encodings for the GC pointer-update MWr poster.
package gc_updt_wr_pkg;

  localparam logic [1:0] FMT_3DW_DATA = 2'b10;
  localparam logic [1:0] FMT_4DW_DATA = 2'b11;
  localparam logic [4:0] TYPE_MWR     = 5'b00000;
  localparam logic [9:0] MWR_LEN_DW   = 10'd2;
  localparam logic [3:0] BE_ALL       = 4'hF;

  localparam logic [6:0] ST_IDLE = 7'b0000001;
  localparam logic [6:0] ST_REQ  = 7'b0000010;
  localparam logic [6:0] ST_BUFW = 7'b0000100;
  localparam logic [6:0] ST_B0   = 7'b0001000;
  localparam logic [6:0] ST_B1   = 7'b0010000;
  localparam logic [6:0] ST_B2   = 7'b0100000;
  localparam logic [6:0] ST_ACK  = 7'b1000000;

  // Payload DWs go out little-endian: byte 0 lands in bits [31:24].
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/gc_updt_wr_hdr.sv
// Combinational builder for the three 64-bit beats of the 2-DW MWr TLP.
module gc_tlp_hdr
  import gc_updt_wr_pkg::*;
(
  input  logic [63:0] i_host_addr,
  input  logic [63:0] i_gc_addr,
  input  logic [15:0] i_completer_id,
  output logic [63:0] o_beat0,
  output logic [63:0] o_beat1,
  output logic [63:0] o_beat2,
  output logic [7:0]  o_trem_n
);

  logic        w_is_4dw;
  logic [31:0] w_dw0;
  logic [31:0] w_dw1;
  logic [31:0] w_addr_lo;
  logic [31:0] w_p0;
  logic [31:0] w_p1;
  logic        w_unused_addr_lsbs;

  assign w_is_4dw  = |i_host_addr[63:32];
  assign w_dw0     = {1'b0, (w_is_4dw ? FMT_4DW_DATA : FMT_3DW_DATA), TYPE_MWR,
                      1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, MWR_LEN_DW};
  assign w_dw1     = {i_completer_id, 8'h00, BE_ALL, BE_ALL};
  assign w_addr_lo = {i_host_addr[31:2], 2'b00};
  assign w_p0      = bswap32(i_gc_addr[31:0]);
  assign w_p1      = bswap32(i_gc_addr[63:32]);
  assign w_unused_addr_lsbs = ^i_host_addr[1:0];

  // A 3DW header leaves the payload straddling beats, so the last beat is half empty.
  assign o_beat0  = {w_dw0, w_dw1};
  assign o_beat1  = w_is_4dw ? {i_host_addr[63:32], w_addr_lo} : {w_addr_lo, w_p0};
  assign o_beat2  = w_is_4dw ? {w_p0, w_p1} : {w_p1, 32'h0000_0000};
  assign o_trem_n = w_is_4dw ? 8'h00 : 8'h0F;

endmodule

// File: rtl/gc_updt_wr.sv
// Posts a 64-bit GC pointer to host memory as one MWr TLP per update request.
module gc_updt_wr
  import gc_updt_wr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gc_updt,
  input  logic [63:0] gc_addr,
  output logic        gc_updt_ack,
  input  logic [63:0] gc_host_addr,
  input  logic [15:0] cfg_completer_id,
  input  logic        cfg_bus_mstr_enable,
  output logic        tx_req,
  input  logic        tx_gnt,
  output logic        tx_done,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  output logic [31:0] gc_updt_cnt
);

  logic [6:0]  r_state;
  logic [63:0] r_gc_addr;
  logic [63:0] r_host_addr;
  logic [15:0] r_cid;
  logic        r_post_ack;
  logic        r_tx_req;
  logic        r_tx_done;
  logic        r_ack;
  logic [63:0] r_td;
  logic [7:0]  r_trem_n;
  logic        r_sof_n;
  logic        r_eof_n;
  logic        r_src_rdy_n;
  logic [31:0] r_cnt;

  logic [63:0] w_beat0;
  logic [63:0] w_beat1;
  logic [63:0] w_beat2;
  logic [7:0]  w_trem_n;
  logic        w_start;
  logic        w_taken;
  logic        w_unused_tbuf;

  gc_tlp_hdr u_hdr (
    .i_host_addr    (r_host_addr),
    .i_gc_addr      (r_gc_addr),
    .i_completer_id (r_cid),
    .o_beat0        (w_beat0),
    .o_beat1        (w_beat1),
    .o_beat2        (w_beat2),
    .o_trem_n       (w_trem_n)
  );

  // r_post_ack blanks the first IDLE cycle so a requester still holding gc_updt is not posted twice.
  assign w_start = (r_state == ST_IDLE) && gc_updt && !r_ack && cfg_bus_mstr_enable && !r_post_ack;
  assign w_taken = !trn_tdst_rdy_n;
  assign w_unused_tbuf = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gc_addr   <= '0;
      r_host_addr <= '0;
      r_cid       <= '0;
      r_post_ack  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_done   <= 1'b0;
      r_ack       <= 1'b0;
      r_td        <= '0;
      r_trem_n    <= 8'hFF;
      r_sof_n     <= 1'b1;
      r_eof_n     <= 1'b1;
      r_src_rdy_n <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_tx_done  <= 1'b0;
      r_ack      <= 1'b0;
      r_post_ack <= (r_state == ST_ACK);
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_gc_addr   <= gc_addr;
          r_host_addr <= gc_host_addr;
          r_cid       <= cfg_completer_id;
          r_tx_req    <= 1'b1;
          r_state     <= ST_REQ;
        end
        ST_REQ: if (tx_gnt) r_state <= ST_BUFW;
        ST_BUFW: if (trn_tbuf_av[1]) begin
          r_td        <= w_beat0;
          r_trem_n    <= 8'h00;
          r_sof_n     <= 1'b0;
          r_src_rdy_n <= 1'b0;
          r_state     <= ST_B0;
        end
        ST_B0: if (w_taken) begin
          r_td    <= w_beat1;
          r_sof_n <= 1'b1;
          r_state <= ST_B1;
        end
        ST_B1: if (w_taken) begin
          r_td     <= w_beat2;
          r_trem_n <= w_trem_n;
          r_eof_n  <= 1'b0;
          r_state  <= ST_B2;
        end
        ST_B2: if (w_taken) begin
          r_src_rdy_n <= 1'b1;
          r_eof_n     <= 1'b1;
          r_trem_n    <= 8'hFF;
          r_tx_req    <= 1'b0;
          r_tx_done   <= 1'b1;
          r_ack       <= 1'b1;
          r_cnt       <= r_cnt + 32'd1;
          r_state     <= ST_ACK;
        end
        ST_ACK: r_state <= ST_IDLE;
        default: begin
          r_state     <= ST_IDLE;
          r_tx_req    <= 1'b0;
          r_src_rdy_n <= 1'b1;
          r_sof_n     <= 1'b1;
          r_eof_n     <= 1'b1;
        end
      endcase
    end
  end

  assign gc_updt_ack    = r_ack;
  assign tx_req         = r_tx_req;
  assign tx_done        = r_tx_done;
  assign trn_td         = r_td;
  assign trn_trem_n     = r_trem_n;
  assign trn_tsof_n     = r_sof_n;
  assign trn_teof_n     = r_eof_n;
  assign trn_tsrc_rdy_n = r_src_rdy_n;
  assign gc_updt_cnt    = r_cnt;

endmodule

// File: tb/tb_gc_updt_wr.sv
// Scoreboard bench for gc_updt_wr: a reference model queues expected beats/acks, a monitor checks them.
module tb_gc_updt_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gc_updt = 1'b0;
  logic [63:0] gc_addr = '0;
  logic [63:0] gc_host_addr = '0;
  logic [15:0] cfg_completer_id = '0;
  logic        cfg_bus_mstr_enable = 1'b1;
  logic        gc_updt_ack, tx_req, tx_done;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic [31:0] gc_updt_cnt;
  logic        tx_gnt, trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;

  // Responder: 0 = always ready, 1 = random, 2 = manual values
  int          mode = 0;
  logic        man_gnt = 1'b1, man_dst_n = 1'b0;
  logic [3:0]  man_tbuf = 4'hF;
  logic        rnd_gnt = 1'b0, rnd_dst_n = 1'b1;
  logic [3:0]  rnd_tbuf = 4'h0;

  assign tx_gnt         = (mode == 0) ? 1'b1  : (mode == 1) ? rnd_gnt  : man_gnt;
  assign trn_tbuf_av    = (mode == 0) ? 4'hF  : (mode == 1) ? rnd_tbuf : man_tbuf;
  assign trn_tdst_rdy_n = (mode == 0) ? 1'b0  : (mode == 1) ? rnd_dst_n : man_dst_n;

  always #5 clk = ~clk;

  gc_updt_wr dut (
    .clk(clk), .rst_n(rst_n), .gc_updt(gc_updt), .gc_addr(gc_addr), .gc_updt_ack(gc_updt_ack),
    .gc_host_addr(gc_host_addr), .cfg_completer_id(cfg_completer_id),
    .cfg_bus_mstr_enable(cfg_bus_mstr_enable), .tx_req(tx_req), .tx_gnt(tx_gnt), .tx_done(tx_done),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .gc_updt_cnt(gc_updt_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        sof_n;
    logic        eof_n;
    logic [7:0]  trem_n;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] exp_cnt = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference model: the TLP as a list of beats, straight from the packet layout rules.
  task automatic model_push(input logic [63:0] ga, input logic [63:0] ha, input logic [15:0] cid);
    logic [31:0] dw0, dw1, p0, p1, alo;
    beat_t b;
    bit four;
    four = (ha[63:32] != 32'h0);
    dw0  = four ? 32'h6000_0002 : 32'h4000_0002;
    dw1  = {cid, 16'h00FF};
    p0   = bswap(ga[31:0]);
    p1   = bswap(ga[63:32]);
    alo  = ha[31:0] & 32'hFFFF_FFFC;
    b.data = {dw0, dw1}; b.sof_n = 1'b0; b.eof_n = 1'b1; b.trem_n = 8'h00;
    exp_q.push_back(b);
    b.data = four ? {ha[63:32], alo} : {alo, p0}; b.sof_n = 1'b1;
    exp_q.push_back(b);
    b.data = four ? {p0, p1} : {p1, 32'h0}; b.eof_n = 1'b0; b.trem_n = four ? 8'h00 : 8'h0F;
    exp_q.push_back(b);
    exp_cnt = exp_cnt + 32'd1;
    ack_q.push_back(exp_cnt);
  endtask

  // Monitor: every presented beat must match the head of the queue; pop when accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_done) n_done++;
      if (!trn_tsrc_rdy_n) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got td=%0h expected no beat", trn_td);
        end else begin
          chk("beat_data", trn_td, exp_q[0].data);
          chk("beat_sof_n", 64'(trn_tsof_n), 64'(exp_q[0].sof_n));
          chk("beat_eof_n", 64'(trn_teof_n), 64'(exp_q[0].eof_n));
          if (!exp_q[0].eof_n) chk("beat_trem_n", 64'(trn_trem_n), 64'(exp_q[0].trem_n));
          if (!trn_tdst_rdy_n) void'(exp_q.pop_front());
        end
      end
      if (gc_updt_ack) begin
        chk("done_with_ack", 64'(tx_done), 64'd1);
        if (ack_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ack: got cnt=%0d expected no ack", gc_updt_cnt);
        end else begin
          chk("ack_cnt", 64'(gc_updt_cnt), 64'(ack_q.pop_front()));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_gnt   = ($urandom % 3) != 0;
    rnd_tbuf  = 4'($urandom);
    rnd_dst_n = ($urandom % 3) == 0;
  end

  task automatic start_update(input logic [63:0] ga, input logic [63:0] ha, input logic [15:0] cid);
    gc_addr = ga; gc_host_addr = ha; cfg_completer_id = cid;
    model_push(ga, ha, cid);
    gc_updt = 1'b1;
  endtask

  // Hold the request until ack; scramble gc_addr once the DUT has latched it.
  task automatic wait_ack(input int budget, input int extra_hold);
    int n = 0;
    bit got = 0;
    while (!got && n < budget) begin
      @(posedge clk); #1; n++;
      if (gc_updt_ack) got = 1;
      else if (tx_req) gc_addr = {$urandom, $urandom};
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", n);
    end
    repeat (extra_hold) @(posedge clk);
    if (extra_hold > 0) #1;
    gc_updt = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_first_beat(output int n);
    n = 0;
    while (trn_tsrc_rdy_n && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_req"}, 64'(tx_req), 64'd0);
    chk({tag, "_tx_done"}, 64'(tx_done), 64'd0);
    chk({tag, "_ack"}, 64'(gc_updt_ack), 64'd0);
    chk({tag, "_src_rdy_n"}, 64'(trn_tsrc_rdy_n), 64'd1);
    chk({tag, "_sof_n"}, 64'(trn_tsof_n), 64'd1);
    chk({tag, "_eof_n"}, 64'(trn_teof_n), 64'd1);
    chk({tag, "_trem_n"}, 64'(trn_trem_n), 64'hFF);
    chk({tag, "_td"}, trn_td, 64'd0);
    chk({tag, "_cnt"}, 64'(gc_updt_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] ga, ha;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3DW header, IDLE-to-first-beat latency with everything ready
    start_update(64'h0000_0001_2345_6780, 64'h0000_0000_8000_0000, 16'h0100);
    wait_first_beat(n);
    chk("latency", 64'(n), 64'd3);
    wait_ack(100, 0);
    chk("cnt_first", 64'(gc_updt_cnt), 64'd1);
    chk("done_first", 64'(n_done), 64'd1);

    // 4DW header
    start_update({$urandom, $urandom}, 64'h0000_0010_0000_1000, 16'hBEEF);
    wait_ack(100, 0);

    // Destination stalls for 5 cycles while B1 is presented
    mode = 2; man_gnt = 1'b1; man_tbuf = 4'hF; man_dst_n = 1'b0;
    start_update({$urandom, $urandom}, 64'h0000_0000_1234_5678, 16'h0A0B);
    wait_first_beat(n);
    @(posedge clk); #1;
    man_dst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    man_dst_n = 1'b0;
    wait_ack(100, 0);
    chk("done_after_stall", 64'(n_done), 64'd3);
    chk("beats_left_stall", 64'(exp_q.size()), 64'd0);

    // Late grant and no posted credit: nothing may go out early
    man_gnt = 1'b0; man_tbuf = 4'h0;
    start_update({$urandom, $urandom}, 64'h0000_0003_0000_0040, 16'h1111);
    for (int i = 0; i < 14; i++) begin
      if (i == 10) man_gnt = 1'b1;
      @(posedge clk); #1;
      chk("src_rdy_wait", 64'(trn_tsrc_rdy_n), 64'd1);
      chk("no_early_ack", 64'(gc_updt_ack), 64'd0);
    end
    man_tbuf = 4'h2;
    wait_ack(100, 0);

    // Reset in the middle of the packet: drop it, resend after release
    mode = 0;
    start_update(64'hCAFE_F00D_0123_4567, 64'h0000_0000_0000_2000, 16'h2222);
    wait_first_beat(n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midtlp");
    exp_q.delete(); ack_q.delete(); exp_cnt = '0; n_done = 0;
    model_push(64'hCAFE_F00D_0123_4567, 64'h0000_0000_0000_2000, 16'h2222);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ack(100, 0);
    chk("cnt_after_reset", 64'(gc_updt_cnt), 64'd1);
    chk("done_after_reset", 64'(n_done), 64'd1);

    // Bus mastering off: request must wait
    cfg_bus_mstr_enable = 1'b0;
    start_update({$urandom, $urandom}, 64'h0000_0000_0000_3000, 16'h3333);
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_req_disabled", 64'(tx_req), 64'd0);
    end
    cfg_bus_mstr_enable = 1'b1;
    wait_ack(100, 0);

    // Requester drops gc_updt late: still exactly one packet
    start_update({$urandom, $urandom}, 64'h0000_0000_0000_4000, 16'h4444);
    wait_ack(100, 2);
    repeat (10) begin
      @(posedge clk); #1;
      chk("no_double_post", 64'(tx_req), 64'd0);
    end

    // Random traffic with random handshakes
    mode = 1;
    for (int k = 0; k < 25; k++) begin
      ga = {$urandom, $urandom};
      ha = ($urandom % 2) ? {$urandom, $urandom} : {32'h0, $urandom};
      start_update(ga, ha, 16'($urandom));
      wait_ack(500, 0);
    end
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("final_beats_left", 64'(exp_q.size()), 64'd0);
    chk("final_acks_left", 64'(ack_q.size()), 64'd0);
    chk("final_cnt", 64'(gc_updt_cnt), 64'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gc_updt_wr.md
GC_UPDT_WR -- requirements
Module: gc_updt_wr

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: gc_updt in 1 (update request, held until ack); gc_addr in 64 (value to post); gc_updt_ack out 1 (one-cycle completion pulse).
REQ-003 SHALL have ports: gc_host_addr in 64 (host DW-aligned target, quasi-static); cfg_completer_id in 16 (requester ID); cfg_bus_mstr_enable in 1.
REQ-004 SHALL have ports: tx_req out 1; tx_gnt in 1; tx_done out 1 (TX arbiter handshake).
REQ-005 SHALL have ports: trn_td out 64; trn_trem_n out 8; trn_tsof_n out 1; trn_teof_n out 1; trn_tsrc_rdy_n out 1; trn_tdst_rdy_n in 1; trn_tbuf_av in 4 (bit 1 = posted credit).
REQ-006 SHALL have port gc_updt_cnt out 32 (posted updates, wraps).

Function
REQ-007 States SHALL be IDLE, REQ, BUFW, B0, B1, B2, ACK.
REQ-008 IDLE: when gc_updt=1, ack=0 and cfg_bus_mstr_enable=1, SHALL latch gc_addr and gc_host_addr, assert tx_req, go to REQ.
REQ-009 REQ: tx_req SHALL stay high until tx_gnt=1, then go to BUFW.
REQ-010 BUFW: SHALL go to B0 once trn_tbuf_av[1]=1.
REQ-011 Each beat state SHALL drive trn_tsrc_rdy_n=0 and advance only on a clock edge with trn_tdst_rdy_n=0; otherwise it SHALL hold trn_td/trem_n/sof/eof stable.
REQ-012 TLP SHALL be MWr, TC=0, TD=0, EP=0, attr=0, length=2 DW, tag=0, first/last BE=4'hF, requester ID=cfg_completer_id.
REQ-013 If latched host addr[63:32]!=0: 4DW header; B0={DW0 fmt=2'b11,DW1}, B1={addr[63:32],addr[31:2],2'b00}, B2={P0,P1}, trem_n=8'h00.
REQ-014 If latched host addr[63:32]==0: 3DW header fmt=2'b10; B0={DW0,DW1}, B1={addr[31:2],2'b00,P0}, B2={P1,32'h0}, trem_n=8'h0F.
REQ-015 P0 SHALL be gc_addr[31:0] and P1 gc_addr[63:32], each byte-swapped (byte 0 in bits [31:24]).
REQ-016 trn_tsof_n=0 only in B0, trn_teof_n=0 only in B2; after B2 accepted SHALL pulse tx_done one cycle, deassert tx_req, go to ACK.
REQ-017 ACK: SHALL pulse gc_updt_ack one cycle, increment gc_updt_cnt (modulo 2^32), return to IDLE.
REQ-018 IDLE SHALL not start a new update in the cycle directly after ACK, avoiding double-post of a request dropped on ack.
REQ-019 cfg_bus_mstr_enable falling after REQ SHALL not abort the in-flight TLP.
REQ-020 gc_addr changes while not in IDLE SHALL not affect the TLP.
REQ-021 Latency IDLE->first beat SHALL be 3 cycles with tx_gnt, tbuf_av and tdst_rdy all asserted immediately.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state IDLE, tx_req=0, tx_done=0, gc_updt_ack=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=8'hFF, trn_td=0, gc_updt_cnt=0.
REQ-023 Reset mid-TLP SHALL drop the packet; no ack SHALL be issued for it.

Structure
REQ-024 Shared package SHALL hold the MWr fmt/type codes, 3DW/4DW fmt constants and the one-hot state encodings.
REQ-025 A sub-module gc_tlp_hdr SHALL combinationally build DW0/DW1 and the address DWs from latched inputs; the FSM stays in gc_updt_wr.

Verification
REQ-026 gc_addr=64'h0000_0001_2345_6780, host=64'h0000_0000_8000_0000, all ready -> 3 beats, B1={32'h8000_0000,32'h8067_4523}, trem_n=8'h0F, one ack, cnt=1.
REQ-027 host=64'h0000_0010_0000_1000 -> DW0 fmt=2'b11, B1={32'h0000_0010,32'h0000_1000}, trem_n=8'h00.
REQ-028 trn_tdst_rdy_n=1 for 5 cycles during B1 -> B1 data held constant, exactly 3 accepted beats, single tx_done.
REQ-029 tx_gnt delayed 10 cycles and trn_tbuf_av[1]=0 for 4 more -> tsrc_rdy_n stays 1 until both met; no ack early.
REQ-030 rst_n low during B1 -> outputs at reset values immediately; after release with gc_updt held, full TLP resent, cnt=1.
REQ-031 cfg_bus_mstr_enable=0 with gc_updt=1 for 20 cycles -> no tx_req; enable -> update proceeds normally.
